// File: rtl/and16b_phase_sched.sv
// rtl/and16b_phase_sched.sv - two-requester scheduler for a four-phase power-clocked and16b datapath
// Round-robin grant, operand hold across P1..P4, result capture at end of P2, held response.
module and16b_phase_sched #(
    parameter int PHASE_CYC = 2,
    parameter int W         = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    input  logic [W-1:0] dp_out,
    output logic         clkpos,
    output logic         clkpos2,
    output logic         clkneg,
    output logic         clkneg2,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_id,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, P1, P2, P3, P4, RESP} state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       cnt_done;
    logic       last_id;
    logic       grant0;
    logic       grant1;

    assign cnt_done = (cnt == 4'(PHASE_CYC - 1));

    // last_id == 1 means req0 currently holds priority
    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_id)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) state_nx = P1;
            end
            P1:      if (cnt_done) state_nx = P2;
            P2:      if (cnt_done) state_nx = P3;
            P3:      if (cnt_done) state_nx = P4;
            P4:      if (cnt_done) state_nx = RESP;
            RESP:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req0_ready = grant0 && !rst;
    assign req1_ready = grant1 && !rst;
    assign clkpos     = (state == P1);
    assign clkpos2    = (state == P2);
    assign clkneg     = (state == P3);
    assign clkneg2    = (state == P4);
    assign res_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last_id  <= 1'b1;
            dp_a     <= '0;
            dp_b     <= '0;
            res_data <= '0;
            res_id   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
            if (grant0) begin
                dp_a    <= req0_a;
                dp_b    <= req0_b;
                res_id  <= 1'b0;
                last_id <= 1'b0;
            end else if (grant1) begin
                dp_a    <= req1_a;
                dp_b    <= req1_b;
                res_id  <= 1'b1;
                last_id <= 1'b1;
            end
            // datapath output is settled by the end of the second phase
            if (state == P2 && cnt_done) res_data <= dp_out;
        end
    end

endmodule

// File: tb/tb_and16b_phase_sched.sv
// tb/tb_and16b_phase_sched.sv - directed self-checking bench for and16b_phase_sched
module tb_and16b_phase_sched;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;

    // PHASE_CYC=2 instance
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] dp_a, dp_b, dp_out, res_data;
    logic        clkpos, clkpos2, clkneg, clkneg2;
    logic        res_valid, res_ready, res_id, busy;

    // PHASE_CYC=1 instance
    logic        q0_valid, q0_ready, q1_valid, q1_ready;
    logic [15:0] q0_a, q0_b, q1_a, q1_b;
    logic [15:0] e_a, e_b, e_out, e_data;
    logic        e_pos, e_pos2, e_neg, e_neg2;
    logic        e_valid, e_ready, e_id, e_busy;

    always #5 clk = ~clk;

    // datapath model: result only meaningful during the second phase
    assign dp_out = clkpos2 ? (dp_a & dp_b) : 16'hdead;
    assign e_out  = e_pos2 ? (e_a & e_b) : 16'hdead;

    and16b_phase_sched #(.PHASE_CYC(2), .W(16)) u0 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_out(dp_out),
        .clkpos(clkpos), .clkpos2(clkpos2), .clkneg(clkneg), .clkneg2(clkneg2),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .busy(busy)
    );

    and16b_phase_sched #(.PHASE_CYC(1), .W(16)) u1 (
        .clk(clk), .rst(rst),
        .req0_valid(q0_valid), .req0_ready(q0_ready), .req0_a(q0_a), .req0_b(q0_b),
        .req1_valid(q1_valid), .req1_ready(q1_ready), .req1_a(q1_a), .req1_b(q1_b),
        .dp_a(e_a), .dp_b(e_b), .dp_out(e_out),
        .clkpos(e_pos), .clkpos2(e_pos2), .clkneg(e_neg), .clkneg2(e_neg2),
        .res_valid(e_valid), .res_ready(e_ready), .res_data(e_data), .res_id(e_id),
        .busy(e_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("excl0", 32'($onehot0({clkpos, clkpos2, clkneg, clkneg2})), 32'd1);
        chk("idle0", 32'(busy || {clkpos, clkpos2, clkneg, clkneg2} == 4'b0), 32'd1);
        chk("excl1", 32'($onehot0({e_pos, e_pos2, e_neg, e_neg2})), 32'd1);
        chk("idle1", 32'(e_busy || {e_pos, e_pos2, e_neg, e_neg2} == 4'b0), 32'd1);
    end

    // called on the grant cycle; accepts the result on its first RESP cycle
    task automatic wait_result(input logic [15:0] exp_data, input logic exp_id, input logic keep);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && !keep) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end while (!res_valid && n < 40);
        chk("latency", 32'(n), 32'd9);
        chk("res_data", 32'(res_data), 32'(exp_data));
        chk("res_id", 32'(res_id), 32'(exp_id));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [3:0] ph;
        logic       seen;
        logic       id;
        int         n;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; res_ready = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        q0_valid = 0; q1_valid = 0; e_ready = 0;
        q0_a = 0; q0_b = 0; q1_a = 0; q1_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_dp_a", 32'(dp_a), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);

        // single op with backpressure and a req1 arriving during RESP
        rst = 1'b0;
        req0_valid = 1; req0_a = 16'hf0f0; req0_b = 16'h3cff;
        #1;
        chk("grant0_ready0", 32'(req0_ready), 32'd1);
        chk("grant0_ready1", 32'(req1_ready), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 0;
            ph = 4'b1000 >> ((c - 1) / 2);
            chk("phase", 32'({clkpos, clkpos2, clkneg, clkneg2}), 32'(ph));
            chk("dp_a_hold", 32'(dp_a), 32'hf0f0);
        end
        @(negedge clk);
        req1_valid = 1; req1_a = 16'h1234; req1_b = 16'hff00;
        for (int h = 0; h < 5; h++) begin
            #1;
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data", 32'(res_data), 32'h30f0);
            chk("bp_id", 32'(res_id), 32'd0);
            chk("bp_nogrant", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        chk("bp_still", 32'(res_valid), 32'd1);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        #1;
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_grant1", 32'(req1_ready), 32'd1);
        wait_result(16'h1200, 1'b1, 1'b0);

        // both valid after reset: 0, 1, 0
        rst = 1;
        @(negedge clk);
        rst = 0;
        req0_valid = 1; req0_a = 16'haaaa; req0_b = 16'h0ff0;
        req1_valid = 1; req1_a = 16'h5555; req1_b = 16'hffff;
        #1;
        chk("rr0_ready0", 32'(req0_ready), 32'd1);
        chk("rr0_ready1", 32'(req1_ready), 32'd0);
        wait_result(16'h0aa0, 1'b0, 1'b1);
        #1;
        chk("rr1_ready1", 32'(req1_ready), 32'd1);
        chk("rr1_ready0", 32'(req0_ready), 32'd0);
        wait_result(16'h5555, 1'b1, 1'b1);
        #1;
        chk("rr2_ready0", 32'(req0_ready), 32'd1);
        chk("rr2_ready1", 32'(req1_ready), 32'd0);
        wait_result(16'h0aa0, 1'b0, 1'b0);

        // reset during P3 aborts the operation
        req0_valid = 1; req0_a = 16'hffff; req0_b = 16'hffff;
        #1;
        chk("ab_grant", 32'(req0_ready), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 0;
        end
        chk("ab_in_p3", 32'(clkneg), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("ab_phases", 32'({clkpos, clkpos2, clkneg, clkneg2}), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_dp_a", 32'(dp_a), 32'd0);
        chk("ab_data", 32'(res_data), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("ab_no_result", 32'(seen), 32'd0);
        req1_valid = 1; req1_a = 16'h00ff; req1_b = 16'h0f0f;
        #1;
        chk("ab_regrant", 32'(req1_ready), 32'd1);
        wait_result(16'h000f, 1'b1, 1'b0);

        // PHASE_CYC=1 sweep with random operands
        for (int i = 0; i < 6; i++) begin
            id = i[0];
            q0_a = 16'($urandom); q0_b = 16'($urandom);
            q1_a = 16'($urandom); q1_b = 16'($urandom);
            q0_valid = !id; q1_valid = id;
            #1;
            chk("sw_ready", 32'(id ? q1_ready : q0_ready), 32'd1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) begin
                    q0_valid = 0;
                    q1_valid = 0;
                end
            end while (!e_valid && n < 40);
            chk("sw_latency", 32'(n), 32'd5);
            chk("sw_data", 32'(e_data), 32'(id ? (q1_a & q1_b) : (q0_a & q0_b)));
            chk("sw_id", 32'(e_id), 32'(id));
            e_ready = 1;
            @(negedge clk);
            e_ready = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/and16b_phase_sched.md
AND16B_PHASE_SCHED -- requirements
Module: and16b_phase_sched

Interface
- REQ-001: Parameter PHASE_CYC, default 2, is the clk cycles per power-clock quarter-phase; legal range 1..15.
- REQ-002: Parameter W, default 16, is the operand and result width.
- REQ-003: Port clk  input  1  single system clock; all state updates on its rising edge.
- REQ-004: Port rst  input  1  reset, synchronous and active-high.
- REQ-005: Ports req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
- REQ-006: Ports req0_ready / req1_ready  output  1  operation from requester 0/1 accepted this cycle.
- REQ-007: Ports req0_a, req0_b, req1_a, req1_b  input  W  operands of requester 0/1.
- REQ-008: Ports dp_a, dp_b  output  W  operand registers driving the shared and16b datapath a/b inputs.
- REQ-009: Port dp_out  input  W  and16b datapath result.
- REQ-010: Ports clkpos, clkpos2, clkneg, clkneg2  output  1  power-clock phase enables to the datapath.
- REQ-011: Port res_valid  output  1  result available; res_ready  input  1  consumer accepts result.
- REQ-012: Port res_data  output  W  captured result; res_id  output  1  index of the requester that owns it.
- REQ-013: Port busy  output  1  high in every state except IDLE.

Function
- REQ-014: The FSM SHALL have states IDLE, P1, P2, P3, P4 and RESP, encoded as one-hot or binary at implementer's choice.
- REQ-015: In IDLE with at least one reqN_valid high, the block SHALL grant exactly one requester, pulse its reqN_ready for that single cycle, load its operands into dp_a/dp_b, set res_id to N, and enter P1 next cycle.
- REQ-016: Arbitration SHALL be round-robin: the most recently granted requester has lower priority; after reset req0 has priority.
- REQ-017: reqN_ready SHALL be low in every state except IDLE, and low in IDLE when reqN_valid is low.
- REQ-018: Each of P1..P4 SHALL last exactly PHASE_CYC cycles, tracked by an internal counter that resets on every state entry.
- REQ-019: clkpos SHALL be high only in P1, clkpos2 only in P2, clkneg only in P3 and clkneg2 only in P4; at most one phase output is high in any cycle.
- REQ-020: dp_a/dp_b SHALL hold constant from the grant cycle through the end of P4.
- REQ-021: res_data SHALL capture dp_out on the last cycle of P2 and hold it until the next capture.
- REQ-022: After the last cycle of P4, the block SHALL enter RESP and drive res_valid high.
- REQ-023: res_valid SHALL stay high with res_data and res_id stable until res_ready is sampled high; the transfer completes in that cycle and the FSM returns to IDLE next cycle.
- REQ-024: If res_ready is already high on the first RESP cycle, the transfer SHALL complete in that cycle.
- REQ-025: Latency from the grant cycle T SHALL be fixed: P1 starts at T+1 and res_valid rises at T+1+4*PHASE_CYC.
- REQ-026: A new grant SHALL occur no earlier than the IDLE cycle after the result transfer, giving a throughput of at most one operation per 4*PHASE_CYC+2 cycles.
- REQ-027: A requester dropping valid while not granted SHALL be ignored with no state change.

Reset
- REQ-028: When rst is sampled high, the block SHALL enter IDLE on that edge and drive all phase outputs, busy, res_valid and both reqN_ready low, set dp_a, dp_b and res_data to 0 and res_id to 0, and set the round-robin pointer to favour req0.
- REQ-029: rst asserted mid-operation (any of P1..P4 or RESP) SHALL abort the operation with no result delivered; all phase outputs SHALL be low in the cycle after the reset edge.
- REQ-030: rst SHALL take precedence over every other input in the same cycle.

Verification (PHASE_CYC=2)
- REQ-031: Single op: req0 a=16'hF0F0, b=16'h3CFF, grant at cycle 0 -> clkpos high in cycles 1-2, clkpos2 in 3-4, clkneg in 5-6, clkneg2 in 7-8; res_valid at 9 with res_data=16'h30F0 and res_id=0.
- REQ-032: Both valid after reset -> req0 granted first, req1 granted at the first IDLE cycle after req0's transfer, then req0 again if it is still valid.
- REQ-033: Backpressure: res_ready held low for 5 cycles in RESP -> res_valid, res_data and res_id stable for the whole hold, no grant occurs, and IDLE is reached one cycle after res_ready rises.
- REQ-034: rst pulsed during P3 -> all phase outputs low the next cycle, res_valid never asserts, and a following request completes normally.
- REQ-035: Phase-exclusivity check runs throughout all tests: at most one of clkpos, clkpos2, clkneg and clkneg2 is high in any cycle, and none is high while busy is low.
- REQ-036: PHASE_CYC=1 sweep: random operands from both requesters -> res_data equals a&b for the owning requester and res_valid rises 5 cycles after each grant.
